// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//
// Staggered reset sequencer. Waits for the (synchronised) lock input, holds
// every reset output for P_RST_CYCLE cycles, then releases the channels one
// at a time, lowest index first, with P_RST_CYCLE cycles between releases.
// Losing lock or a soft-reset request restarts the whole sequence.
//
// The external reset i_rst is asynchronous on assertion. Its deassertion is
// retimed through a P_SYNC_STAGES-flop chain before the FSM may advance.
//
// Optional build macro:
//   RST_SEQ_LOCK_FILTER_EN - require lock_s to be high for 8 consecutive
//                            cycles before leaving WAIT_LOCK.
// -----------------------------------------------------------------------------
module rst_seq_gen #(
    parameter int P_CHANNELS    = 4,    // 1..8
    parameter int P_RST_CYCLE   = 16,   // 0..65535
    parameter int P_SYNC_STAGES = 2     // 2..4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_lock,
    input  logic                  i_soft_rst,
    output logic [P_CHANNELS-1:0] o_rst,
    output logic                  o_rst_done,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Terminal count of the stagger counter: a phase of P_RST_CYCLE cycles
    // ends on the edge where the counter reads P_RST_CYCLE-1.
    localparam logic [15:0] LP_TERM      = (P_RST_CYCLE == 0) ? 16'd0
                                                              : 16'(P_RST_CYCLE - 1);
    // With a zero-length stagger there is nothing to hold or stagger, so the
    // FSM jumps straight from WAIT_LOCK to DONE.
    localparam bit          LP_ZERO_HOLD = (P_RST_CYCLE == 0);

    // Synchroniser chains
    logic [P_SYNC_STAGES-1:0] rst_sync_q;
    logic [P_SYNC_STAGES-1:0] lock_sync_q;

    // FSM state and registered outputs
    state_t                   state_q;
    logic [P_CHANNELS-1:0]    rst_q;
    logic                     done_q;
    logic [15:0]              cnt_q;

    // Helper terms
    logic                     run_en;
    logic                     lock_s;
    logic                     lock_ok;
    logic                     restart;
    logic [P_CHANNELS-1:0]    rst_shift;
    logic                     last_rel;
    logic                     cnt_hit;
    logic [15:0]              cnt_inc;

    // Reset-release synchroniser: fills with ones after i_rst falls; the FSM
    // only advances once the last stage is set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[P_SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Lock synchroniser: i_lock is asynchronous to i_clk.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[P_SYNC_STAGES-2:0], i_lock};
        end
    end

    assign run_en  = rst_sync_q[P_SYNC_STAGES-1];
    assign lock_s  = lock_sync_q[P_SYNC_STAGES-1];

    // Lock loss and soft reset share one restart path, so a coincident pair
    // produces exactly one restart.
    assign restart = !lock_s || i_soft_rst;

    // Releasing the next channel is a left shift of the reset vector, which
    // keeps the outputs monotonic (no released bit above a held bit).
    assign rst_shift = rst_q << 1;
    assign last_rel  = (rst_shift == '0);
    assign cnt_hit   = (cnt_q == LP_TERM);
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);

`ifdef RST_SEQ_LOCK_FILTER_EN
    logic [2:0] filt_q;

    // Lock filter: counts consecutive lock_s highs while waiting for lock;
    // any low sample, a soft reset or leaving WAIT_LOCK clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            filt_q <= '0;
        end else if (run_en && (state_q == ST_WAIT_LOCK) && lock_s && !i_soft_rst) begin
            if (filt_q != 3'd7) begin
                filt_q <= filt_q + 3'd1;
            end
        end else begin
            filt_q <= '0;
        end
    end

    // Eighth consecutive high sample: seven already counted plus this one.
    assign lock_ok = lock_s && (filt_q == 3'd7);
`else
    assign lock_ok = lock_s;
`endif

    // Sequencer FSM with registered reset vector, done flag and counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_WAIT_LOCK;
            rst_q   <= '1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (run_en) begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    rst_q  <= '1;
                    done_q <= 1'b0;
                    cnt_q  <= '0;
                    if (!i_soft_rst && lock_ok) begin
                        if (LP_ZERO_HOLD) begin
                            state_q <= ST_DONE;
                            rst_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                end

                // HOLD and RELEASE differ only in how many channels are
                // already free; both end a phase by freeing the next one.
                ST_HOLD, ST_RELEASE: begin
                    if (restart) begin
                        state_q <= ST_WAIT_LOCK;
                        rst_q   <= '1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_hit) begin
                        rst_q <= rst_shift;
                        cnt_q <= '0;
                        if (last_rel) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                ST_DONE: begin
                    cnt_q <= '0;
                    if (restart) begin
                        state_q <= ST_WAIT_LOCK;
                        rst_q   <= '1;
                        done_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_WAIT_LOCK;
                    rst_q   <= '1;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_rst      = rst_q;
    assign o_rst_done = done_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
//
// Three instances share the stimulus:
//   A: 4 channels, stagger 4, 2 sync stages
//   B: 4 channels, stagger 0, 2 sync stages
//   C: 1 channel,  stagger 3, 3 sync stages
// A reference model computes every output from the time elapsed since the
// sequence started (channel k free once elapsed >= (k+1)*P). Directed tasks
// add fixed expected values taken from the timing examples.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

`ifdef RST_SEQ_LOCK_FILTER_EN
    localparam int NEED = 8;
`else
    localparam int NEED = 1;
`endif
    localparam int LF = NEED - 1;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_lock;
    logic       i_soft_rst;

    logic [3:0] a_rst;  logic a_done;  logic [1:0] a_st;
    logic [3:0] b_rst;  logic b_done;  logic [1:0] b_st;
    logic [0:0] c_rst;  logic c_done;  logic [1:0] c_st;

    always #5 clk = ~clk;

    rst_seq_gen #(.P_CHANNELS(4), .P_RST_CYCLE(4), .P_SYNC_STAGES(2)) dut_a (
        .i_clk(clk), .i_rst(i_rst), .i_lock(i_lock), .i_soft_rst(i_soft_rst),
        .o_rst(a_rst), .o_rst_done(a_done), .o_state(a_st));

    rst_seq_gen #(.P_CHANNELS(4), .P_RST_CYCLE(0), .P_SYNC_STAGES(2)) dut_b (
        .i_clk(clk), .i_rst(i_rst), .i_lock(i_lock), .i_soft_rst(i_soft_rst),
        .o_rst(b_rst), .o_rst_done(b_done), .o_state(b_st));

    rst_seq_gen #(.P_CHANNELS(1), .P_RST_CYCLE(3), .P_SYNC_STAGES(3)) dut_c (
        .i_clk(clk), .i_rst(i_rst), .i_lock(i_lock), .i_soft_rst(i_soft_rst),
        .o_rst(c_rst), .o_rst_done(c_done), .o_state(c_st));

    logic [20:0] act_all;
    assign act_all = {a_rst, a_done, a_st, b_rst, b_done, b_st,
                      3'b000, c_rst, c_done, c_st};

    int total;
    int bad;

    // ---------------- reference model ----------------
    int         m_n [3] = '{4, 4, 1};
    int         m_p [3] = '{4, 0, 3};
    int         m_s [3] = '{2, 2, 3};
    int         m_phase  [3];   // 0 waiting for lock, 1 sequence running
    int         m_e0     [3];   // edge number on which the sequence started
    int         m_consec [3];   // consecutive lock highs while waiting
    int         m_rdy    [3];   // edges since i_rst was released
    logic [3:0] m_lk     [3];   // i_lock delayed by the synchroniser depth
    int         g_edge;

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_phase[m]  = 0;
            m_consec[m] = 0;
            m_rdy[m]    = 0;
            m_lk[m]     = 4'b0000;
        end
    endtask

    task automatic model_step();
        logic lks;
        g_edge++;
        for (int m = 0; m < 3; m++) begin
            if (i_rst) begin
                m_phase[m]  = 0;
                m_consec[m] = 0;
                m_rdy[m]    = 0;
                m_lk[m]     = 4'b0000;
            end else begin
                lks = m_lk[m][m_s[m]-1];
                if (m_rdy[m] >= m_s[m]) begin
                    if (m_phase[m] == 1) begin
                        if (!lks || i_soft_rst) m_phase[m] = 0;
                    end else if (i_soft_rst || !lks) begin
                        m_consec[m] = 0;
                    end else begin
                        m_consec[m]++;
                        if (m_consec[m] >= NEED) begin
                            m_phase[m]  = 1;
                            m_e0[m]     = g_edge;
                            m_consec[m] = 0;
                        end
                    end
                end
                m_lk[m] = {m_lk[m][2:0], i_lock};
                if (m_rdy[m] < 100) m_rdy[m]++;
            end
        end
    endtask

    function automatic logic [6:0] exp_of(input int m);
        logic [3:0] r;
        logic       d;
        logic [1:0] s;
        int         el;
        r = 4'b0000;
        d = 1'b0;
        s = 2'd0;
        for (int k = 0; k < m_n[m]; k++) r[k] = 1'b1;
        if (m_phase[m] == 1) begin
            el = g_edge - m_e0[m];
            for (int k = 0; k < m_n[m]; k++) r[k] = !(el >= (k + 1) * m_p[m]);
            d = (el >= m_n[m] * m_p[m]);
            s = d ? 2'd3 : ((el < m_p[m]) ? 2'd1 : 2'd2);
        end
        return {r, d, s};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {exp_of(0), exp_of(1), exp_of(2)};
    endfunction

    // Instance A timeline from the worked example, indexed by edges since HOLD.
    function automatic logic [6:0] tbl_a(input int el);
        if (el < 4)       return 7'b1111_0_01;
        else if (el < 8)  return 7'b1110_0_10;
        else if (el < 12) return 7'b1100_0_10;
        else if (el < 16) return 7'b1000_0_10;
        else              return 7'b0000_1_11;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst = 1'b1; i_lock = 1'b1; i_soft_rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({a_rst, a_done, a_st} !== 7'b1111_0_00) begin
            bad++; $display("FAIL reset_a got=%b exp=%b", {a_rst, a_done, a_st}, 7'b1111_0_00);
        end
        total++;
        if ({b_rst, b_done, b_st, c_rst, c_done, c_st} !== 11'b1111_0_00_1_0_00) begin
            bad++; $display("FAIL reset_bc got=%b exp=%b",
                            {b_rst, b_done, b_st, c_rst, c_done, c_st}, 11'b1111_0_00_1_0_00);
        end
        i_lock = 1'b0;
        i_rst  = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_reset j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
        end
    endtask

    task automatic test_sequence();
        int el;
        i_lock = 1'b1;
        for (int j = 1; j <= 22 + LF; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_seq j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
            el = j - (3 + LF);
            total++;
            if (el < 0) begin
                if ({a_rst, a_done, a_st} !== 7'b1111_0_00) begin
                    bad++; $display("FAIL seq_a_wait j=%0d got=%b exp=%b", j, {a_rst, a_done, a_st}, 7'b1111_0_00);
                end
            end else if ({a_rst, a_done, a_st} !== tbl_a(el)) begin
                bad++; $display("FAIL seq_a j=%0d got=%b exp=%b", j, {a_rst, a_done, a_st}, tbl_a(el));
            end
            total++;
            if ({b_rst, b_done, b_st} !== ((el < 0) ? 7'b1111_0_00 : 7'b0000_1_11)) begin
                bad++; $display("FAIL seq_b_zero j=%0d got=%b exp=%b", j, {b_rst, b_done, b_st},
                                (el < 0) ? 7'b1111_0_00 : 7'b0000_1_11);
            end
            el = j - (4 + LF);
            total++;
            if ({c_rst, c_done, c_st} !== ((el < 0) ? 4'b1_0_00 : (el < 3) ? 4'b1_0_01 : 4'b0_1_11)) begin
                bad++; $display("FAIL seq_c_single j=%0d got=%b exp=%b", j, {c_rst, c_done, c_st},
                                (el < 0) ? 4'b1_0_00 : (el < 3) ? 4'b1_0_01 : 4'b0_1_11);
            end
        end
    endtask

    task automatic test_lock_loss();
        i_lock = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_loss1 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
            if (j == 2) begin
                total++;
                if (a_st !== 2'd3) begin
                    bad++; $display("FAIL loss_done_hold got=%0d exp=3", a_st);
                end
            end
            if (j == 3) begin
                total++;
                if ({a_rst, a_done, a_st} !== 7'b1111_0_00) begin
                    bad++; $display("FAIL loss_from_done got=%b exp=%b", {a_rst, a_done, a_st}, 7'b1111_0_00);
                end
            end
        end
        i_lock = 1'b1;
        for (int j = 1; j <= 13 + LF; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_loss2 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
        end
        total++;
        if (a_rst !== 4'b1100) begin
            bad++; $display("FAIL loss_mid_release got=%b exp=1100", a_rst);
        end
        i_lock = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_loss3 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
            if (j == 2) begin
                total++;
                if ({a_rst, a_st} !== 6'b1000_10) begin
                    bad++; $display("FAIL loss_latency got=%b exp=100010", {a_rst, a_st});
                end
            end
            if (j == 3) begin
                total++;
                if ({a_rst, a_done, a_st} !== 7'b1111_0_00) begin
                    bad++; $display("FAIL loss_restart got=%b exp=%b", {a_rst, a_done, a_st}, 7'b1111_0_00);
                end
            end
        end
        i_lock = 1'b1;
        for (int j = 1; j <= 21 + LF; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_loss4 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
        end
        total++;
        if ({a_rst, a_done} !== 5'b0000_1) begin
            bad++; $display("FAIL loss_resequence got=%b exp=00001", {a_rst, a_done});
        end
    endtask

    task automatic test_soft_reset();
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        total++;
        if ({a_rst, a_done, a_st} !== 7'b1111_0_00) begin
            bad++; $display("FAIL soft_next_edge got=%b exp=%b", {a_rst, a_done, a_st}, 7'b1111_0_00);
        end
        for (int j = 1; j <= LF + 1; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_soft1 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
        end
        total++;
        if (a_st !== 2'd1) begin
            bad++; $display("FAIL soft_hold_entry got=%0d exp=1", a_st);
        end
        for (int j = 1; j <= 16; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_soft2 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
            if (j == 4 || j == 15 || j == 16) begin
                total++;
                if ({a_rst, a_done, a_st} !== tbl_a(j)) begin
                    bad++; $display("FAIL soft_rerelease j=%0d got=%b exp=%b", j, {a_rst, a_done, a_st}, tbl_a(j));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        for (int j = 1; j <= LF + 9; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_async1 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
        end
        total++;
        if (a_rst !== 4'b1100) begin
            bad++; $display("FAIL async_setup got=%b exp=1100", a_rst);
        end
        #2;
        i_rst = 1'b1;
        #1;
        total++;
        if ({a_rst, a_done, a_st} !== 7'b1111_0_00) begin
            bad++; $display("FAIL async_immediate_a got=%b exp=%b", {a_rst, a_done, a_st}, 7'b1111_0_00);
        end
        total++;
        if ({b_rst, b_done, b_st, c_rst, c_done, c_st} !== 11'b1111_0_00_1_0_00) begin
            bad++; $display("FAIL async_immediate_bc got=%b exp=%b",
                            {b_rst, b_done, b_st, c_rst, c_done, c_st}, 11'b1111_0_00_1_0_00);
        end
        model_reset();
        tick();
        i_rst = 1'b0;
        for (int j = 1; j <= 20 + LF; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_async2 j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
            if (j <= 3 + LF) begin
                total++;
                if (a_st !== ((j < 3 + LF) ? 2'd0 : 2'd1)) begin
                    bad++; $display("FAIL async_release_idle j=%0d got=%0d exp=%0d", j, a_st,
                                    (j < 3 + LF) ? 0 : 1);
                end
            end
        end
    endtask

    task automatic test_random();
        int rst_left;
        rst_left = 0;
        for (int j = 1; j <= 800; j++) begin
            tick();
            total++;
            if (act_all !== exp_vec()) begin
                bad++; $display("FAIL model_random j=%0d got=%h exp=%h", j, act_all, exp_vec());
            end
            if ($urandom_range(0, 39) == 0) i_lock = ~i_lock;
            i_soft_rst = ($urandom_range(0, 34) == 0);
            if (rst_left > 0) begin
                rst_left--;
                i_rst = (rst_left > 0);
            end else if ($urandom_range(0, 149) == 0) begin
                rst_left = $urandom_range(1, 3);
                i_rst    = 1'b1;
            end
        end
        i_rst = 1'b0;
        i_soft_rst = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        g_edge = 0;
        i_rst      = 1'b1;
        i_lock     = 1'b0;
        i_soft_rst = 1'b0;
        model_reset();
        test_reset();
        test_sequence();
        test_lock_loss();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
